// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter: shares one burst memory port between an i-side line
// reader and a d-side line reader/writer. Writes are split into BURST_LEN
// beats; read bursts are reassembled and routed back by matching mem_raddr
// against each side's pending line address.
// Optional: define MEM_ARB_D_PRIORITY_EN for fixed d-side priority instead of
// round-robin arbitration.
module banked_mem_arbiter #(
  parameter int  ADDR_WIDTH = 32,
  parameter int  BUS_WIDTH  = 64,
  parameter int  BURST_LEN  = 4,
  localparam int LINE_WIDTH = BUS_WIDTH * BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  err
);

  localparam int             BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RCMD, S_WBURST} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_read_q, mem_write_q;
  logic [BUS_WIDTH-1:0]    mem_wdata_q;
  logic [BCW-1:0]          wbeat_q;
  logic                    rd_d_q;      // outstanding read command belongs to d-side
  logic                    i_pend_q, d_pend_q, d_wr_q;
  logic [ADDR_WIDTH-1:0]   i_paddr_q, d_paddr_q;
  logic                    i_resp_q, d_resp_q, err_q;
  logic [LINE_WIDTH-1:0]   i_rdata_q, d_rdata_q;
  logic [BCW-1:0]          rbeat_q;
  logic [LINE_WIDTH-1:0]   rline_q;
  logic [LINE_WIDTH-1:0]   rline_full;
  logic                    rlast, i_hit, d_hit;
  logic                    i_elig, d_elig, grant_d;

  // A side may only compete when idle and not in its own resp cycle
  assign i_elig = i_read && !i_pend_q && !i_resp_q;
  assign d_elig = (d_read || d_write) && !d_pend_q && !d_resp_q;

`ifdef MEM_ARB_D_PRIORITY_EN
  assign grant_d = d_elig;
`else
  logic rr_q;  // 1: d-side preferred on the next tie
  assign grant_d = d_elig && (!i_elig || rr_q);
`endif

  // Last beat of a read burst completes the line; match against pending reads
  assign rlast = mem_rvalid && (rbeat_q == LAST_BEAT);
  assign i_hit = rlast && i_pend_q && (mem_raddr == i_paddr_q);
  assign d_hit = rlast && d_pend_q && !d_wr_q && (mem_raddr == d_paddr_q);

  // Line as it will look once the final beat lands
  always_comb begin
    rline_full = rline_q;
    rline_full[(BURST_LEN-1)*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
  end

  // Read-return collector: beat counter and line buffer, free-running vs issue FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbeat_q <= '0;
      rline_q <= '0;
    end else if (mem_rvalid) begin
      rline_q[int'(rbeat_q)*BUS_WIDTH +: BUS_WIDTH] <= mem_rdata;
      rbeat_q <= rlast ? '0 : rbeat_q + 1'b1;
    end
  end

  // Issue FSM plus pending/resp bookkeeping for both requesters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      wbeat_q     <= '0;
      rd_d_q      <= 1'b0;
      i_pend_q    <= 1'b0;
      d_pend_q    <= 1'b0;
      d_wr_q      <= 1'b0;
      i_paddr_q   <= '0;
      d_paddr_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifndef MEM_ARB_D_PRIORITY_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;

      // Return routing; both sides may complete off the same burst
      if (i_hit) begin
        i_rdata_q <= rline_full;
        i_resp_q  <= 1'b1;
        i_pend_q  <= 1'b0;
      end
      if (d_hit) begin
        d_rdata_q <= rline_full;
        d_resp_q  <= 1'b1;
        d_pend_q  <= 1'b0;
      end
      if (rlast && !i_hit && !d_hit) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (i_elig || d_elig) begin
`ifndef MEM_ARB_D_PRIORITY_EN
            rr_q <= !grant_d;
`endif
            if (grant_d) begin
              mem_addr_q <= d_addr;
              if (d_write) begin
                // read+write together is illegal; the write wins
                if (d_read) err_q <= 1'b1;
                mem_write_q <= 1'b1;
                mem_wdata_q <= d_wdata[BUS_WIDTH-1:0];
                wbeat_q     <= '0;
                d_pend_q    <= 1'b1;
                d_wr_q      <= 1'b1;
                state_q     <= S_WBURST;
              end else begin
                mem_read_q  <= 1'b1;
                rd_d_q      <= 1'b1;
                state_q     <= S_RCMD;
              end
            end else begin
              mem_addr_q <= i_addr;
              mem_read_q <= 1'b1;
              rd_d_q     <= 1'b0;
              state_q    <= S_RCMD;
            end
          end
        end
        S_RCMD: begin
          if (mem_ready) begin
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            if (rd_d_q) begin
              d_pend_q  <= 1'b1;
              d_wr_q    <= 1'b0;
              d_paddr_q <= mem_addr_q;
            end else begin
              i_pend_q  <= 1'b1;
              i_paddr_q <= mem_addr_q;
            end
            state_q <= S_IDLE;
          end
        end
        S_WBURST: begin
          if (mem_ready) begin
            if (wbeat_q == LAST_BEAT) begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
              d_resp_q    <= 1'b1;
              d_pend_q    <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              wbeat_q     <= wbeat_q + 1'b1;
              mem_wdata_q <= d_wdata[(int'(wbeat_q) + 1)*BUS_WIDTH +: BUS_WIDTH];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Bench for banked_mem_arbiter: directed scenarios plus randomized rounds
// against a transaction-level model of grants, bursts and line routing.
module tb_banked_mem_arbiter;

`ifdef MEM_ARB_D_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0, mem_addr, mem_raddr = '0;
  logic         i_read = 0, d_read = 0, d_write = 0;
  logic [255:0] i_rdata, d_rdata, d_wdata = '0;
  logic         i_resp, d_resp, mem_read, mem_write, err;
  logic [63:0]  mem_wdata, mem_rdata = '0;
  logic         mem_ready = 0, mem_rvalid = 0;

  int total = 0, bad = 0;
  bit last_d;  // side granted most recently (1 = d); reset makes i-side win a tie

  always #5 clk = ~clk;

  banked_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err(err)
  );

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Which side the arbiter should pick given who is eligible
  function automatic bit pred_d(bit ie, bit de);
    if (ie && de) return PRIO ? 1'b1 : !last_d;
    return de;
  endfunction

  task automatic wait_cmd(output bit found);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        found = 1'b1;
        return;
      end
    end
    total++; bad++;
    $display("FAIL cmd_timeout: no mem command within 30 cycles");
  endtask

  task automatic accept_read(input logic [31:0] a, input int stall, input string nm);
    bit f;
    wait_cmd(f);
    if (!f) return;
    for (int s = 0; s < stall; s++) begin
      total++;
      if (mem_read !== 1'b1 || mem_addr !== a) begin
        bad++;
        $display("FAIL %s_hold: read=%b addr=%h, want read=1 addr=%h", nm, mem_read, mem_addr, a);
      end
      @(negedge clk);
    end
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== a) begin
      bad++;
      $display("FAIL %s_cmd: read=%b write=%b addr=%h, want read=1 write=0 addr=%h",
               nm, mem_read, mem_write, mem_addr, a);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (mem_read !== 1'b0) begin
      bad++;
      $display("FAIL %s_drop: read=%b after accept, want 0", nm, mem_read);
    end
  endtask

  // Feeds the write burst; rnd=0 stalls two cycles before beat 2
  task automatic write_burst(input logic [31:0] a, input logic [255:0] line, input bit rnd,
                             input string nm);
    int k = 0;
    bit f, rdy;
    wait_cmd(f);
    if (!f) return;
    for (int c = 0; c < 40 && k < 4; c++) begin
      total++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== a || mem_wdata !== line[k*64 +: 64]) begin
        bad++;
        $display("FAIL %s_beat%0d: write=%b addr=%h wdata=%h, want write=1 addr=%h wdata=%h",
                 nm, k, mem_write, mem_addr, mem_wdata, a, line[k*64 +: 64]);
      end
      rdy = rnd ? ($urandom_range(0, 1) == 1) : !(c == 2 || c == 3);
      mem_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
    end
    mem_ready = 1'b0;
    total++;
    if (k != 4 || d_resp !== 1'b1 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL %s_done: beats=%0d d_resp=%b write=%b, want beats=4 d_resp=1 write=0",
               nm, k, d_resp, mem_write);
    end
  endtask

  // Drives one 4-beat return; ends on the negedge where resp should be visible
  task automatic send_burst(input logic [31:0] a, input logic [255:0] line);
    for (int j = 0; j < 4; j++) begin
      mem_rvalid = 1'b1;
      mem_raddr  = a;
      mem_rdata  = line[j*64 +: 64];
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({i_resp, d_resp, mem_read, mem_write, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: i_resp=%b d_resp=%b read=%b write=%b err=%b, want all 0",
               i_resp, d_resp, mem_read, mem_write, err);
    end
    total++;
    if (i_rdata !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data: i_rdata=%h d_rdata=%h addr=%h wdata=%h, want 0",
               i_rdata, d_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    last_d = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    logic [255:0] line;
    line = {64'h3, 64'h2, 64'h1, 64'h0};
    i_addr = 32'h1000; i_read = 1'b1;
    accept_read(32'h1000, 0, "iread");
    last_d = 1'b0;
    send_burst(32'h1000, line);
    total++;
    if (i_resp !== 1'b1 || i_rdata !== line || d_resp !== 1'b0) begin
      bad++;
      $display("FAIL iread_resp: i_resp=%b d_resp=%b i_rdata=%h, want 1 0 %h", i_resp, d_resp, i_rdata, line);
    end
    i_read = 1'b0;
    @(negedge clk);
    total++;
    if (i_resp !== 1'b0 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL iread_pulse: i_resp=%b read=%b, want 0 0", i_resp, mem_read);
    end
  endtask

  task automatic test_d_write_stall();
    d_addr = 32'h2000; d_wdata = rnd_line(); d_write = 1'b1;
    write_burst(32'h2000, d_wdata, 1'b0, "dwrite");
    last_d = 1'b1;
    d_write = 1'b0;
    @(negedge clk);
    total++;
    if (d_resp !== 1'b0) begin
      bad++;
      $display("FAIL dwrite_pulse: d_resp=%b, want 0", d_resp);
    end
  endtask

  task automatic test_dual_read();
    logic [255:0] li, ld;
    bit fd;
    li = rnd_line(); ld = rnd_line();
    i_addr = 32'h1000; d_addr = 32'h3000;
    i_read = 1'b1; d_read = 1'b1;
    fd = pred_d(1'b1, 1'b1);
    accept_read(fd ? 32'h3000 : 32'h1000, 1, "dual_first");
    accept_read(fd ? 32'h1000 : 32'h3000, 0, "dual_second");
    last_d = !fd;
    send_burst(32'h3000, ld);
    total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== ld) begin
      bad++;
      $display("FAIL dual_d: d_resp=%b i_resp=%b d_rdata=%h, want 1 0 %h", d_resp, i_resp, d_rdata, ld);
    end
    d_read = 1'b0;
    send_burst(32'h1000, li);
    total++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== li) begin
      bad++;
      $display("FAIL dual_i: i_resp=%b d_resp=%b i_rdata=%h, want 1 0 %h", i_resp, d_resp, i_rdata, li);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_same_addr();
    logic [255:0] l;
    bit fd;
    l = rnd_line();
    i_addr = 32'h4000; d_addr = 32'h4000;
    i_read = 1'b1; d_read = 1'b1;
    fd = pred_d(1'b1, 1'b1);
    accept_read(32'h4000, 0, "same_first");
    accept_read(32'h4000, 0, "same_second");
    last_d = !fd;
    send_burst(32'h4000, l);
    total++;
    if (i_resp !== 1'b1 || d_resp !== 1'b1 || i_rdata !== l || d_rdata !== l) begin
      bad++;
      $display("FAIL same_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, want both 1 with %h",
               i_resp, d_resp, i_rdata, d_rdata, l);
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_and_reset();
    bit f;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clean: err=%b, want 0", err);
    end
    // read and write together: write issued, err flagged
    d_addr = 32'h7000; d_wdata = rnd_line(); d_read = 1'b1; d_write = 1'b1;
    wait_cmd(f);
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL rw_both: write=%b read=%b err=%b, want 1 0 1", mem_write, mem_read, err);
    end
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (d_resp !== 1'b1) begin
      bad++;
      $display("FAIL rw_both_resp: d_resp=%b, want 1", d_resp);
    end
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err: err=%b, want 0", err);
    end
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
    // unmatched return
    send_burst(32'h5000, rnd_line());
    total++;
    if (err !== 1'b1 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++;
      $display("FAIL nomatch: err=%b i_resp=%b d_resp=%b, want 1 0 0", err, i_resp, d_resp);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    // reset in the middle of a write burst
    d_addr = 32'h6000; d_wdata = rnd_line(); d_write = 1'b1;
    wait_cmd(f);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (mem_write !== 1'b1) begin
      bad++;
      $display("FAIL midburst: write=%b, want 1", mem_write);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_write, mem_read, err, i_resp, d_resp} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      bad++;
      $display("FAIL rst_async: write=%b read=%b err=%b addr=%h wdata=%h i_rdata=%h, want all 0",
               mem_write, mem_read, err, mem_addr, mem_wdata, i_rdata);
    end
    d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
    @(negedge clk);
    total++;
    if (d_resp !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL rst_noresp: d_resp=%b write=%b, want 0 0", d_resp, mem_write);
    end
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      bit ir, dr, dw, fd, side, i_out, d_out;
      logic [31:0] ia, da;
      logic [31:0] addrs[$];
      int need, dm;
      ir = ($urandom_range(0, 1) == 1);
      dm = $urandom_range(0, 2);
      if (!ir && dm == 0) ir = 1'b1;
      dr = (dm == 1); dw = (dm == 2);
      ia = 32'h8000 + 32'($urandom_range(0, 3)) * 32;
      da = 32'h8000 + 32'($urandom_range(0, 3)) * 32;
      i_addr = ia; d_addr = da; d_wdata = rnd_line();
      i_read = ir; d_read = dr; d_write = dw;
      i_out = 0; d_out = 0;
      need = int'(ir) + int'(dr || dw);
      fd = pred_d(ir, dr || dw);
      for (int n = 0; n < need; n++) begin
        side = (n == 0) ? fd : !fd;
        last_d = side;
        if (side && dw) begin
          write_burst(da, d_wdata, 1'b1, "rnd_wr");
          d_write = 1'b0;
        end else begin
          accept_read(side ? da : ia, $urandom_range(0, 2), side ? "rnd_drd" : "rnd_ird");
          if (side) d_out = 1; else i_out = 1;
        end
      end
      if (i_out) addrs.push_back(ia);
      if (d_out && !(i_out && da == ia)) addrs.push_back(da);
      if (addrs.size() == 2 && $urandom_range(0, 1) == 1) addrs = '{addrs[1], addrs[0]};
      foreach (addrs[b]) begin
        logic [255:0] l;
        bit ei, ed;
        l = rnd_line();
        if ($urandom_range(0, 1) == 1) begin
          mem_rvalid = 1'b0;
          @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
          mem_rvalid = 1'b1; mem_raddr = addrs[b]; mem_rdata = l[j*64 +: 64];
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        ei = i_out && (ia == addrs[b]);
        ed = d_out && (da == addrs[b]);
        total++;
        if (i_resp !== ei || d_resp !== ed || (ei && i_rdata !== l) || (ed && d_rdata !== l)) begin
          bad++;
          $display("FAIL rnd_ret r%0d a=%h: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, want %b %b %h",
                   r, addrs[b], i_resp, d_resp, i_rdata, d_rdata, ei, ed, l);
        end
        if (ei) begin i_out = 0; i_read = 1'b0; end
        if (ed) begin d_out = 0; d_read = 1'b0; end
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      total++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL rnd_end r%0d: i_resp=%b d_resp=%b err=%b, want 0 0 0", r, i_resp, d_resp, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write_stall();
    test_dual_read();
    test_same_addr();
    test_err_and_reset();
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
